// File: rtl/out_channel_checker_if.sv
// out_channel_checker_if: table-load, session-control and out-channel handshake bundle for out_channel_checker.
//   master: drives loadEnable/loadAddress/loadData, expectedCount/start, outValid/outData.
//   slave : drives outReady, finished, success, timedOut, received, mismatchIndex.
interface out_channel_checker_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NExpected = 16
);
  localparam int AW = $clog2(NExpected);
  localparam int CW = $clog2(NExpected + 1);
  logic                          loadEnable;
  logic [AW-1:0]                 loadAddress;
  logic [MemoryElementWidth-1:0] loadData;
  logic [CW-1:0]                 expectedCount;
  logic                          start;
  logic                          outValid;
  logic [MemoryElementWidth-1:0] outData;
  logic                          outReady;
  logic                          finished;
  logic                          success;
  logic                          timedOut;
  logic [CW:0]                   received;
  logic [CW:0]                   mismatchIndex;
  modport master (
    output loadEnable, loadAddress, loadData, expectedCount, start, outValid, outData,
    input  outReady, finished, success, timedOut, received, mismatchIndex
  );
  modport slave (
    input  loadEnable, loadAddress, loadData, expectedCount, start, outValid, outData,
    output outReady, finished, success, timedOut, received, mismatchIndex
  );
endinterface

// File: rtl/out_channel_checker.sv
// out_channel_checker: compares words from a program's out channel against a loaded expected-value table.
//   clock, reset : single clock, synchronous active-high reset.
//   bus (slave)  : table load port, session start/count, outValid/outData/outReady handshake, session status.
//   Optional idle timeout in CHECK enabled by defining OUT_CHANNEL_CHECKER_TIMEOUT_EN.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NExpected = 16,
  parameter int TimeoutCycles = 1000
) (
  input logic clock,
  input logic reset,
  out_channel_checker_if.slave bus
);
  localparam int AW = $clog2(NExpected);
  localparam int CW = $clog2(NExpected + 1);
  localparam int RW = CW + 1;
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  state_t                        r_state, w_next;
  logic [MemoryElementWidth-1:0] r_table [NExpected];
  logic [CW-1:0]                 r_count;
  logic [RW-1:0]                 r_received;
  logic [RW-1:0]                 r_mismatch;
  logic                          r_timed_out;
  logic                          w_begin;
  logic                          w_accept;
  logic                          w_last;
  logic                          w_miss;
  logic                          w_timeout;
  logic [CW-1:0]                 w_count;
  // start is honoured from IDLE and DONE alike, ignored mid-session
  assign w_begin  = bus.start && r_state != CHECK;
  assign w_accept = r_state == CHECK && bus.outValid;
  assign w_last   = r_received + 1'b1 == RW'(r_count);
  assign w_miss   = bus.outData != r_table[r_received[AW-1:0]];
  assign w_count  = bus.expectedCount > CW'(NExpected) ? CW'(NExpected) : bus.expectedCount;
`ifdef OUT_CHANNEL_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] r_idle;
  // r_idle counts idle CHECK cycles already elapsed; the TimeoutCycles-th one ends the session
  assign w_timeout = r_state == CHECK && !w_accept && r_idle == TW'(TimeoutCycles - 1);
  always_ff @(posedge clock)
    r_idle <= (reset || r_state != CHECK || w_accept) ? '0 : r_idle + 1'b1;
`else
  logic w_unused_timeout;
  assign w_timeout = 1'b0;
  assign w_unused_timeout = ^TimeoutCycles;
`endif
  always_comb begin
    w_next = r_state;
    w_next = w_begin ? (w_count == '0 ? DONE : CHECK) : ((w_accept && w_last) || w_timeout) ? DONE : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_received  <= '0;
      r_mismatch  <= '1;
      r_timed_out <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_begin) begin
        r_count     <= w_count;
        r_received  <= '0;
        r_mismatch  <= '1;
        r_timed_out <= 1'b0;
      end else if (w_accept) begin
        r_received <= r_received + 1'b1;
        if (w_miss && &r_mismatch) r_mismatch <= r_received;
      end else if (w_timeout) begin
        r_timed_out <= 1'b1;
      end
    end
  end
  always_ff @(posedge clock)
    if (r_state == IDLE && bus.loadEnable) r_table[bus.loadAddress] <= bus.loadData;
  assign bus.outReady      = r_state == CHECK;
  assign bus.finished      = r_state == DONE;
  assign bus.success       = r_state == DONE && &r_mismatch && !r_timed_out;
  assign bus.timedOut      = r_timed_out;
  assign bus.received      = r_received;
  assign bus.mismatchIndex = r_mismatch;
endmodule

// File: tb/tb_out_channel_checker.sv
// tb_out_channel_checker: directed vector table, hand-written corner sequences and randomized sessions against a reference model.
module tb_out_channel_checker;
  localparam int W = 12;
  localparam int N = 16;
  localparam int T = 10;
  localparam int CW = $clog2(N + 1);
  localparam int RW = CW + 1;
  localparam logic [RW-1:0] NONE = '1;
  typedef struct {
    int                  ntbl;
    logic [3:0][W-1:0]   tbl;
    int                  cnt;
    int                  nw;
    logic [3:0][W-1:0]   w;
    int                  exp_rcv;
    logic [RW-1:0]       exp_mis;
    logic                exp_succ;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] model_tbl [N];
  logic [W-1:0] words [N];
  vec_t vecs [6];
  always #5 clock = ~clock;
  out_channel_checker_if #(.MemoryElementWidth(W), .NExpected(N)) bus ();
  out_channel_checker #(.MemoryElementWidth(W), .NExpected(N), .TimeoutCycles(T)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  function automatic logic [3:0][W-1:0] p4(input int a, input int b, input int c, input int d);
    p4 = {W'(d), W'(c), W'(b), W'(a)};
  endfunction
  function automatic vec_t mk(input int ntbl, input logic [3:0][W-1:0] tbl, input int cnt, input int nw,
                              input logic [3:0][W-1:0] w, input int rcv, input logic [RW-1:0] mis, input logic succ);
    mk.ntbl = ntbl; mk.tbl = tbl; mk.cnt = cnt; mk.nw = nw; mk.w = w;
    mk.exp_rcv = rcv; mk.exp_mis = mis; mk.exp_succ = succ;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  task automatic load(input int a, input logic [W-1:0] d);
    bus.loadEnable = 1'b1;
    bus.loadAddress = 4'(a);
    bus.loadData = d;
    tick;
    bus.loadEnable = 1'b0;
    model_tbl[a] = d;
  endtask
  task automatic start_session(input int cnt);
    bus.expectedCount = CW'(cnt);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask
  task automatic send(input string name, input logic [W-1:0] d);
    bus.outValid = 1'b1;
    bus.outData = d;
    chk({name, "_ready"}, 32'(bus.outReady), 1);
    tick;
    bus.outValid = 1'b0;
  endtask
  task automatic status(input string name, input logic fin, input logic succ, input int rcv, input logic [RW-1:0] mis);
    chk({name, "_finished"}, 32'(bus.finished), 32'(fin));
    chk({name, "_success"}, 32'(bus.success), 32'(succ));
    chk({name, "_received"}, 32'(bus.received), 32'(rcv));
    chk({name, "_mismatch"}, 32'(bus.mismatchIndex), 32'(mis));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt, eff, sent, cyc, gap;
    logic v, found;
    logic [RW-1:0] exp_mis;
    bus.loadEnable = 1'b0; bus.loadAddress = '0; bus.loadData = '0;
    bus.expectedCount = '0; bus.start = 1'b0; bus.outValid = 1'b0; bus.outData = '0;
    vecs[0] = mk(1, p4(5, 0, 0, 0), 1, 1, p4(5, 0, 0, 0), 1, NONE, 1'b1);
    vecs[1] = mk(3, p4(3, 4, 9, 0), 3, 3, p4(3, 7, 9, 0), 3, RW'(1), 1'b0);
    vecs[2] = mk(2, p4(5, 5, 0, 0), 2, 2, p4(5, 5, 0, 0), 2, NONE, 1'b1);
    vecs[3] = mk(0, p4(0, 0, 0, 0), 0, 0, p4(0, 0, 0, 0), 0, NONE, 1'b1);
    vecs[4] = mk(4, p4(1, 2, 3, 4), 4, 4, p4(0, 2, 0, 4), 4, RW'(0), 1'b0);
    vecs[5] = mk(4, p4(1, 2, 3, 4), 4, 4, p4(1, 2, 3, 0), 4, RW'(3), 1'b0);
    tick;
    tick;
    chk("rst_ready", 32'(bus.outReady), 0);
    chk("rst_timedout", 32'(bus.timedOut), 0);
    status("rst", 1'b0, 1'b0, 0, NONE);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_reset;
      for (int a = 0; a < vecs[i].ntbl; a++) load(a, vecs[i].tbl[a]);
      start_session(vecs[i].cnt);
      for (int k = 0; k < vecs[i].nw; k++) send($sformatf("v%0d_w%0d", i, k), vecs[i].w[k]);
      status($sformatf("v%0d", i), 1'b1, vecs[i].exp_succ, vecs[i].exp_rcv, vecs[i].exp_mis);
      bus.outValid = 1'b1;
      bus.outData = 12'h5;
      chk($sformatf("v%0d_extra_ready", i), 32'(bus.outReady), 0);
      tick;
      bus.outValid = 1'b0;
      chk($sformatf("v%0d_extra_rcv", i), 32'(bus.received), 32'(vecs[i].exp_rcv));
    end
    do_reset;
    load(0, 3); load(1, 4); load(2, 9);
    start_session(3);
    send("rmid_w0", 3);
    chk("rmid_rcv1", 32'(bus.received), 1);
    do_reset;
    chk("rmid_ready", 32'(bus.outReady), 0);
    status("rmid", 1'b0, 1'b0, 0, NONE);
    load(0, 7);
    start_session(1);
    send("rmid_post", 7);
    status("rmid_post", 1'b1, 1'b1, 1, NONE);
    do_reset;
    load(0, 5); load(1, 6);
    start_session(2);
    bus.loadEnable = 1'b1; bus.loadAddress = 4'd0; bus.loadData = 12'd9;
    bus.expectedCount = CW'(1); bus.start = 1'b1;
    tick;
    bus.loadEnable = 1'b0; bus.start = 1'b0;
    chk("ign_ready", 32'(bus.outReady), 1);
    chk("ign_rcv", 32'(bus.received), 0);
    send("ign_w0", 5);
    chk("ign_notdone", 32'(bus.finished), 0);
    send("ign_w1", 6);
    status("ign", 1'b1, 1'b1, 2, NONE);
    bus.loadEnable = 1'b1; bus.loadAddress = 4'd1; bus.loadData = 12'hAAA;
    tick;
    bus.loadEnable = 1'b0;
    start_session(2);
    status("again_start", 1'b0, 1'b0, 0, NONE);
    send("again_w0", 5);
    send("again_w1", 6);
    status("again", 1'b1, 1'b1, 2, NONE);
    do_reset;
    load(0, 1); load(1, 2);
    start_session(2);
    send("to_w0", 1);
`ifdef OUT_CHANNEL_CHECKER_TIMEOUT_EN
    for (int k = 0; k < T - 1; k++) tick;
    chk("to_still_check", 32'(bus.outReady), 1);
    tick;
    chk("to_timedout", 32'(bus.timedOut), 1);
    status("to", 1'b1, 1'b0, 1, NONE);
`else
    for (int k = 0; k < 100; k++) tick;
    chk("noto_ready", 32'(bus.outReady), 1);
    chk("noto_timedout", 32'(bus.timedOut), 0);
    status("noto", 1'b0, 1'b0, 1, NONE);
`endif
    for (int s = 0; s < 40; s++) begin
      do_reset;
      for (int a = 0; a < N; a++) load(a, W'($urandom));
      cnt = $urandom_range(0, N + 3);
      eff = cnt > N ? N : cnt;
      found = 1'b0;
      exp_mis = NONE;
      for (int k = 0; k < eff; k++) begin
        words[k] = ($urandom_range(0, 5) == 0) ? W'($urandom) : model_tbl[k];
        if (!found && words[k] != model_tbl[k]) begin
          exp_mis = RW'(k);
          found = 1'b1;
        end
      end
      start_session(cnt);
      sent = 0; cyc = 0; gap = 0;
      while (sent < eff && cyc < 300) begin
        v = gap >= 4 || $urandom_range(0, 2) != 0;
        bus.outValid = v;
        bus.outData = v ? words[sent] : W'($urandom);
        chk($sformatf("rnd%0d_ready", s), 32'(bus.outReady), 1);
        tick;
        cyc++;
        if (v) begin
          sent++;
          gap = 0;
        end else gap++;
      end
      bus.outValid = 1'b0;
      if (sent < eff) chk($sformatf("rnd%0d_budget", s), 32'(sent), 32'(eff));
      chk($sformatf("rnd%0d_timedout", s), 32'(bus.timedOut), 0);
      status($sformatf("rnd%0d", s), 1'b1, !found, eff, exp_mis);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/out_channel_checker.md
OUT_CHANNEL_CHECKER -- requirements
Module: out_channel_checker

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width of each channel word.
REQ-002 SHALL have parameter NExpected, default 16, depth of the expected-value table.
REQ-003 SHALL have parameter TimeoutCycles, default 1000, idle cycles tolerated in CHECK (used only per REQ-030).
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port loadEnable  input  1  writes loadData into the table at loadAddress.
REQ-007 SHALL have port loadAddress  input  $clog2(NExpected)  table index.
REQ-008 SHALL have port loadData  input  MemoryElementWidth  expected word.
REQ-009 SHALL have port expectedCount  input  $clog2(NExpected+1)  words to check; sampled on start.
REQ-010 SHALL have port start  input  1  one-cycle pulse that begins a check session.
REQ-011 SHALL have port outValid  input  1  producer offers outData this cycle.
REQ-012 SHALL have port outData  input  MemoryElementWidth  word from the program's out channel.
REQ-013 SHALL have port outReady  output  1  checker accepts outData this cycle.
REQ-014 SHALL have ports finished, success, timedOut  output  1 each  session status.
REQ-015 SHALL have port received  output  $clog2(NExpected+1)+1  words accepted this session.
REQ-016 SHALL have port mismatchIndex  output  $clog2(NExpected+1)+1  index of first mismatch; all-ones if none.

Function
REQ-017 SHALL implement states IDLE, CHECK, DONE.
REQ-018 IDLE: outReady=0; loadEnable writes the table; start -> CHECK, latch expectedCount, clear received/success/timedOut/finished, set mismatchIndex all-ones.
REQ-019 loadEnable outside IDLE SHALL be ignored; table contents unchanged.
REQ-020 CHECK: outReady=1; a word is accepted on a cycle with outValid && outReady; received increments by 1 that cycle.
REQ-021 Accepted word SHALL be compared with table[received] the same cycle; on first inequality mismatchIndex <= received.
REQ-022 When the accepted word makes received == latched count, next state DONE the following cycle, finished=1.
REQ-023 expectedCount==0 at start SHALL go directly to DONE on the next cycle with success=1.
REQ-024 DONE: outReady=0; finished=1; success=1 iff mismatchIndex all-ones and timedOut=0; holds until start or reset.
REQ-025 start in DONE SHALL begin a new session exactly as from IDLE; start in CHECK SHALL be ignored.
REQ-026 expectedCount > NExpected SHALL be clamped to NExpected at latch time.
REQ-027 outValid in IDLE or DONE SHALL not be accepted and SHALL not change received.
REQ-028 Table read and compare SHALL be single-cycle (zero added latency; acceptance and verdict same edge).

Reset
REQ-029 reset SHALL force IDLE, outReady=0, finished=0, success=0, timedOut=0, received=0, mismatchIndex all-ones, from any state including mid-CHECK; table contents undefined after reset.

Configuration
REQ-030 Macro OUT_CHANNEL_CHECKER_TIMEOUT_EN defined: a counter clears on each accepted word and on entering CHECK, increments each CHECK cycle with no acceptance; reaching TimeoutCycles -> DONE with timedOut=1, success=0.
REQ-031 Macro undefined: no timeout counter; timedOut tied 0; CHECK waits indefinitely.

Verification
REQ-032 Load table[0]=5, start with count 1, send 5 -> finished=1, success=1, received=1, mismatchIndex all-ones on cycle after acceptance.
REQ-033 Load 3,4,9; count 3; send 3,7,9 -> finished=1, success=0, mismatchIndex=1, received=3.
REQ-034 count 2, outValid held high with 5,5 back-to-back -> two words accepted on consecutive cycles, third offer sees outReady=0.
REQ-035 Assert reset after 1 of 3 words accepted -> next cycle IDLE, received=0, finished=0; loadEnable then writes table.
REQ-036 count 0 at start -> finished=1, success=1 next cycle, no words accepted.
REQ-037 With OUT_CHANNEL_CHECKER_TIMEOUT_EN, TimeoutCycles=10, count 2, send one word then idle -> DONE with timedOut=1, success=0 after 10 idle cycles; without macro, still CHECK after 100 cycles.
